// File: rtl/level_tracker_if.sv
// Bundle of game-event inputs and level/lives/segment outputs for level_tracker.
// The master drives events; the slave (the tracker) drives status and segments.
interface level_tracker_if #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned MAX_LEVEL  = 99
);
  localparam int unsigned LW = $clog2(MAX_LEVEL + 1);

  logic                      reset_level;
  logic                      frog_at_top;
  logic                      frog_hit;
  logic [LW-1:0]             level_bin;
  logic [4*NUM_DIGITS-1:0]   level_bcd;
  logic [3:0]                lives;
  logic                      reset_frog;
  logic                      level_wrap;
  logic                      game_over;
  logic [7*NUM_DIGITS-1:0]   o_Segments;

  modport master (
    output reset_level, frog_at_top, frog_hit,
    input  level_bin, level_bcd, lives, reset_frog, level_wrap, game_over, o_Segments
  );

  modport slave (
    input  reset_level, frog_at_top, frog_hit,
    output level_bin, level_bcd, lives, reset_frog, level_wrap, game_over, o_Segments
  );
endinterface

// File: rtl/level_tracker.sv
// Frog-game level/lives tracker: BCD level counter, lives, respawn/game-over
// sequencing and direct active-low seven-segment drive for NUM_DIGITS digits.
module level_tracker #(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned START_LEVEL   = 1,
  parameter int unsigned MAX_LEVEL     = 99,
  parameter int unsigned WRAP_MODE     = 0,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  level_tracker_if.slave  bus
);
  localparam int unsigned LW = $clog2(MAX_LEVEL + 1);
  localparam int unsigned BW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {PLAY, NEXT, HIT, OVER} state_t;

  // Elaboration-time conversion only; the runtime counter never divides.
  function automatic logic [BW-1:0] to_bcd(input int unsigned val);
    logic [BW-1:0] r;
    int unsigned   v;
    r = '0;
    v = val;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] START_BCD = to_bcd(START_LEVEL);

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  state_t          state;
  logic [LW-1:0]   level_bin;
  logic [BW-1:0]   level_bcd;
  logic [3:0]      lives;
  logic            reset_frog;
  logic            level_wrap;
  logic            game_over;
  logic            top_q;
  logic            hit_q;
  logic            top_ev;
  logic            hit_ev;
  logic [7*NUM_DIGITS-1:0] segs;

  assign top_ev = bus.frog_at_top & ~top_q;
  assign hit_ev = bus.frog_hit & ~hit_q;

  always_ff @(posedge clk) begin
    if (!reset_n || bus.reset_level) begin
      state      <= PLAY;
      level_bin  <= LW'(START_LEVEL);
      level_bcd  <= START_BCD;
      lives      <= 4'(LIVES);
      reset_frog <= 1'b0;
      level_wrap <= 1'b0;
      game_over  <= 1'b0;
      top_q      <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      top_q      <= bus.frog_at_top;
      hit_q      <= bus.frog_hit;
      reset_frog <= 1'b0;
      level_wrap <= 1'b0;
      case (state)
        PLAY: begin
          if (top_ev) begin
            state      <= NEXT;
            reset_frog <= 1'b1;
            if (level_bin == LW'(MAX_LEVEL)) begin
              if (WRAP_MODE != 0) begin
                level_bin  <= LW'(START_LEVEL);
                level_bcd  <= START_BCD;
                level_wrap <= 1'b1;
              end
            end else begin
              level_bin <= level_bin + LW'(1);
              level_bcd <= bcd_inc(level_bcd);
            end
          end else if (hit_ev) begin
            state      <= HIT;
            reset_frog <= 1'b1;
            if (lives != 4'd0) lives <= lives - 4'd1;
          end
        end
        NEXT: state <= PLAY;
        // lives already holds the decremented count here
        HIT: begin
          if (lives == 4'd0) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state <= PLAY;
          end
        end
        OVER: game_over <= 1'b1;
        default: state <= PLAY;
      endcase
    end
  end

  // Scan from the most significant digit so leading zeros can be blanked.
  always_comb begin
    logic       higher_zero;
    logic [3:0] d;
    segs        = '1;
    higher_zero = 1'b1;
    d           = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      d           = level_bcd[4*(NUM_DIGITS-1-k) +: 4];
      higher_zero = higher_zero && (d == 4'd0);
      if ((BLANK_LEADING != 0) && higher_zero && (k != NUM_DIGITS - 1))
        segs[7*(NUM_DIGITS-1-k) +: 7] = '1;
      else
        segs[7*(NUM_DIGITS-1-k) +: 7] = seg7(d);
    end
  end

  assign bus.level_bin  = level_bin;
  assign bus.level_bcd  = level_bcd;
  assign bus.lives      = lives;
  assign bus.reset_frog = reset_frog;
  assign bus.level_wrap = level_wrap;
  assign bus.game_over  = game_over;
  assign bus.o_Segments = segs;
endmodule
